// File: rtl/spec_tlb_frontend_if.sv
// Bus bundle between the core, the TLB front end and the page table.
//   Core side : REQ_VALID/REQ_VPN/REQ_READY request, RSP_* response pulse,
//               RES_* speculation resolution pulse, WALK_ERR, FLUSH.
//   Table side: LOOKUP_RQST/LOOKUP_ADDR request, LOOKUP_COMPLETE/LOOKUP_RETURN.
// slave  = the TLB front end, master = whatever drives the core/table side.
interface spec_tlb_frontend_if;
   logic       REQ_VALID;
   logic [3:0] REQ_VPN;
   logic       REQ_READY;
   logic       RSP_VALID;
   logic [3:0] RSP_PPN;
   logic       RSP_SPEC;
   logic       RSP_FAULT;
   logic       RES_VALID;
   logic       RES_OK;
   logic [3:0] RES_PPN;
   logic       WALK_ERR;
   logic       FLUSH;
   logic       LOOKUP_RQST;
   logic [3:0] LOOKUP_ADDR;
   logic       LOOKUP_COMPLETE;
   logic [7:0] LOOKUP_RETURN;

   modport slave (
      input  REQ_VALID, REQ_VPN, FLUSH, LOOKUP_COMPLETE, LOOKUP_RETURN,
      output REQ_READY, RSP_VALID, RSP_PPN, RSP_SPEC, RSP_FAULT,
             RES_VALID, RES_OK, RES_PPN, WALK_ERR, LOOKUP_RQST, LOOKUP_ADDR
   );

   modport master (
      output REQ_VALID, REQ_VPN, FLUSH, LOOKUP_COMPLETE, LOOKUP_RETURN,
      input  REQ_READY, RSP_VALID, RSP_PPN, RSP_SPEC, RSP_FAULT,
             RES_VALID, RES_OK, RES_PPN, WALK_ERR, LOOKUP_RQST, LOOKUP_ADDR
   );
endinterface

// File: rtl/spec_tlb_frontend.sv
// Fully-associative TLB front end with speculative miss responses.
// Hits answer in one cycle; misses answer with VPN+DELTA, walk the page
// table, fill a round-robin entry and then report whether the guess held.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - spec_tlb_frontend_if.slave (request/response/resolution/lookup)
module spec_tlb_frontend #(
   parameter int unsigned TLB_ENTRIES  = 4,
   parameter int unsigned WALK_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spec_tlb_frontend_if.slave   bus
);

   localparam int unsigned VPN_W = 4;
   localparam int unsigned PPN_W = 4;
   localparam int unsigned PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_COOL = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [TLB_ENTRIES-1:0] valid_q, valid_d;
   logic [VPN_W-1:0]       tag_q [TLB_ENTRIES];
   logic [VPN_W-1:0]       tag_d [TLB_ENTRIES];
   logic [PPN_W-1:0]       ppn_q [TLB_ENTRIES];
   logic [PPN_W-1:0]       ppn_d [TLB_ENTRIES];
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [PPN_W-1:0]       delta_q, delta_d;
   logic [VPN_W-1:0]       wvpn_q, wvpn_d;
   logic [PPN_W-1:0]       pred_q, pred_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   rdy_q, rdy_d;
   logic                   rqst_q, rqst_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [PPN_W-1:0]       rsp_ppn_q, rsp_ppn_d;
   logic                   rsp_spec_q, rsp_spec_d;
   logic                   rsp_fault_q, rsp_fault_d;
   logic                   res_valid_q, res_valid_d;
   logic                   res_ok_q, res_ok_d;
   logic [PPN_W-1:0]       res_ppn_q, res_ppn_d;

   logic                   hit_c;
   logic [PPN_W-1:0]       hit_ppn_c;
   logic [PPN_W-1:0]       pred_c;
   logic [VPN_W-1:0]       ret_vpn_c;
   logic [PPN_W-1:0]       ret_ppn_c;
   logic [PTR_W-1:0]       fill_idx_c;

   // Associative match over valid entries; at most one can match.
   always_comb begin
      hit_c     = 1'b0;
      hit_ppn_c = '0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
         if (valid_q[i] && (tag_q[i] == bus.REQ_VPN)) begin
            hit_c     = 1'b1;
            hit_ppn_c = ppn_q[i];
         end
      end
   end

   assign pred_c    = PPN_W'(bus.REQ_VPN + delta_q);
   assign ret_vpn_c = bus.LOOKUP_RETURN[7:4];
   assign ret_ppn_c = bus.LOOKUP_RETURN[3:0];
   // A flush on the fill edge rewinds the pointer before the fill lands.
   assign fill_idx_c = bus.FLUSH ? '0 : ptr_q;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      ppn_d       = ppn_q;
      ptr_d       = ptr_q;
      delta_d     = delta_q;
      wvpn_d      = wvpn_q;
      pred_d      = pred_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      rsp_ppn_d   = rsp_ppn_q;
      rsp_spec_d  = rsp_spec_q;
      rsp_fault_d = rsp_fault_q;
      res_valid_d = 1'b0;
      res_ok_d    = res_ok_q;
      res_ppn_d   = res_ppn_q;

      if (bus.FLUSH) begin
         valid_d = '0;
         ptr_d   = '0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (bus.REQ_VALID) begin
               rsp_valid_d = 1'b1;
               // Flush wins over a same-cycle lookup.
               if (hit_c && !bus.FLUSH) begin
                  rsp_ppn_d   = hit_ppn_c;
                  rsp_spec_d  = 1'b0;
                  rsp_fault_d = 1'b0;
               end else if (err_q) begin
                  rsp_ppn_d   = '0;
                  rsp_spec_d  = 1'b0;
                  rsp_fault_d = 1'b1;
               end else begin
                  rsp_ppn_d   = pred_c;
                  rsp_spec_d  = 1'b1;
                  rsp_fault_d = 1'b0;
                  wvpn_d      = bus.REQ_VPN;
                  pred_d      = pred_c;
                  cnt_d       = '0;
                  state_d     = ST_WALK;
               end
            end
         end

         ST_WALK: begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
            // Completion outranks a timeout landing on the same edge.
            if (bus.LOOKUP_COMPLETE) begin
               res_valid_d = 1'b1;
               state_d     = ST_COOL;
               if (ret_vpn_c == wvpn_q) begin
                  valid_d[fill_idx_c] = 1'b1;
                  tag_d[fill_idx_c]   = wvpn_q;
                  ppn_d[fill_idx_c]   = ret_ppn_c;
                  ptr_d = (fill_idx_c == PTR_W'(TLB_ENTRIES - 1)) ? '0
                                                                  : PTR_W'(fill_idx_c + 1'b1);
                  delta_d   = PPN_W'(ret_ppn_c - wvpn_q);
                  res_ok_d  = (ret_ppn_c == pred_q);
                  res_ppn_d = ret_ppn_c;
               end else begin
                  res_ok_d  = 1'b0;
                  res_ppn_d = '0;
                  err_d     = 1'b1;
               end
            end else if (cnt_d == CNT_W'(WALK_TIMEOUT)) begin
               res_valid_d = 1'b1;
               res_ok_d    = 1'b0;
               res_ppn_d   = '0;
               err_d       = 1'b1;
               state_d     = ST_COOL;
            end
         end

         ST_COOL: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rdy_d  = (state_d == ST_IDLE);
      rqst_d = (state_d == ST_WALK);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
            tag_q[i] <= '0;
            ppn_q[i] <= '0;
         end
         ptr_q       <= '0;
         delta_q     <= '0;
         wvpn_q      <= '0;
         pred_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         rdy_q       <= 1'b1;
         rqst_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_ppn_q   <= '0;
         rsp_spec_q  <= 1'b0;
         rsp_fault_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_ok_q    <= 1'b0;
         res_ppn_q   <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         ppn_q       <= ppn_d;
         ptr_q       <= ptr_d;
         delta_q     <= delta_d;
         wvpn_q      <= wvpn_d;
         pred_q      <= pred_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         rdy_q       <= rdy_d;
         rqst_q      <= rqst_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ppn_q   <= rsp_ppn_d;
         rsp_spec_q  <= rsp_spec_d;
         rsp_fault_q <= rsp_fault_d;
         res_valid_q <= res_valid_d;
         res_ok_q    <= res_ok_d;
         res_ppn_q   <= res_ppn_d;
      end
   end

   assign bus.REQ_READY   = rdy_q;
   assign bus.RSP_VALID   = rsp_valid_q;
   assign bus.RSP_PPN     = rsp_ppn_q;
   assign bus.RSP_SPEC    = rsp_spec_q;
   assign bus.RSP_FAULT   = rsp_fault_q;
   assign bus.RES_VALID   = res_valid_q;
   assign bus.RES_OK      = res_ok_q;
   assign bus.RES_PPN     = res_ppn_q;
   assign bus.WALK_ERR    = err_q;
   assign bus.LOOKUP_RQST = rqst_q;
   assign bus.LOOKUP_ADDR = wvpn_q;

endmodule
